// File: rtl/dual_port_memory_arbiter_pkg.sv
// Shared types and helpers for dual_port_memory_arbiter: round-robin pick
// function and index-width helper.
package dual_port_memory_arbiter_pkg;

    localparam int unsigned MAX_REQUESTERS = 8;
    localparam int unsigned MAX_IW         = 3;

    typedef struct packed {
        logic              valid;
        logic [MAX_IW-1:0] index;
    } rr_pick_t;

    function automatic int unsigned index_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First requester after `last`, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQUESTERS-1:0] request,
        input logic [MAX_IW-1:0]         last,
        input int unsigned               n
    );
        rr_pick_t          pick;
        logic [MAX_IW-1:0] idx;
        pick = '0;
        idx  = '0;
        for (int unsigned k = 1; k <= n; k++) begin
            idx = MAX_IW'((32'(last) + k) % n);
            if (!pick.valid && request[idx]) begin
                pick.valid = 1'b1;
                pick.index = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dual_port_memory_arbiter_round_robin.sv
// round_robin_arbiter: one-hot round-robin grant with an owned pointer that
// loads the winner on every grant and resets to REQUESTERS-1.
module round_robin_arbiter
    import dual_port_memory_arbiter_pkg::*;
#(
    parameter  int unsigned REQUESTERS = 2,
    localparam int unsigned IW         = index_width(REQUESTERS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REQUESTERS-1:0] request,
    output logic [REQUESTERS-1:0] grant,
    output logic [IW-1:0]         grant_index
);

    logic [IW-1:0] last;
    rr_pick_t      pick;

    always_comb begin
        pick        = rr_pick(MAX_REQUESTERS'(request), MAX_IW'(last), REQUESTERS);
        grant_index = pick.index[IW-1:0];
        grant       = '0;
        if (pick.valid) begin
            grant[grant_index] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last <= IW'(REQUESTERS - 1);
        end else if (pick.valid) begin
            last <= grant_index;
        end
    end

endmodule

// File: rtl/dual_port_memory_arbiter.sv
// Shares one dual-port memory between REQUESTERS clients with independent
// round-robin read and write arbiters. Optional macro DUAL_PORT_ARBITER_BYPASS_EN
// forwards same-cycle same-address write data to the read response.
module dual_port_memory_arbiter
    import dual_port_memory_arbiter_pkg::*;
#(
    parameter  int unsigned WIDTH      = 8,
    parameter  int unsigned DEPTH      = 512,
    parameter  int unsigned REQUESTERS = 2,
    localparam int unsigned AW         = $clog2(DEPTH),
    localparam int unsigned IW         = index_width(REQUESTERS)
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [REQUESTERS-1:0]       req_valid,
    input  logic [REQUESTERS-1:0]       req_write,
    input  logic [REQUESTERS*AW-1:0]    req_addr,
    input  logic [REQUESTERS*WIDTH-1:0] req_data,
    output logic [REQUESTERS-1:0]       req_ready,
    output logic [REQUESTERS-1:0]       resp_valid,
    output logic [WIDTH-1:0]            resp_data,
    output logic                        mem_read_enable,
    output logic [AW-1:0]               mem_read_addr,
    input  logic [WIDTH-1:0]            mem_read_data,
    output logic                        mem_write_enable,
    output logic [AW-1:0]               mem_write_addr,
    output logic [WIDTH-1:0]            mem_write_data
);

    logic [REQUESTERS-1:0] read_grant;
    logic [REQUESTERS-1:0] write_grant;
    logic [IW-1:0]         read_index;
    logic [IW-1:0]         write_index;
    logic [IW-1:0]         resp_owner;
    logic                  resp_pending;

    round_robin_arbiter #(.REQUESTERS(REQUESTERS)) read_arbiter (
        .clock       (clock),
        .reset_n     (reset_n),
        .request     (req_valid & ~req_write),
        .grant       (read_grant),
        .grant_index (read_index)
    );

    round_robin_arbiter #(.REQUESTERS(REQUESTERS)) write_arbiter (
        .clock       (clock),
        .reset_n     (reset_n),
        .request     (req_valid & req_write),
        .grant       (write_grant),
        .grant_index (write_index)
    );

    always_comb begin
        req_ready        = read_grant | write_grant;
        mem_read_enable  = |read_grant;
        mem_write_enable = |write_grant;
        mem_read_addr    = '0;
        mem_write_addr   = '0;
        mem_write_data   = '0;
        if (mem_read_enable) begin
            mem_read_addr = req_addr[read_index*AW +: AW];
        end
        if (mem_write_enable) begin
            mem_write_addr = req_addr[write_index*AW +: AW];
            mem_write_data = req_data[write_index*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_pending <= 1'b0;
            resp_owner   <= '0;
        end else begin
            resp_pending <= mem_read_enable;
            if (mem_read_enable) begin
                resp_owner <= read_index;
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        if (resp_pending) begin
            resp_valid[resp_owner] = 1'b1;
        end
    end

`ifdef DUAL_PORT_ARBITER_BYPASS_EN
    logic             bypass_hit;
    logic [WIDTH-1:0] bypass_data;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bypass_hit  <= 1'b0;
            bypass_data <= '0;
        end else begin
            bypass_hit <= mem_read_enable && mem_write_enable
                          && (mem_read_addr == mem_write_addr);
            if (mem_write_enable) begin
                bypass_data <= mem_write_data;
            end
        end
    end

    assign resp_data = bypass_hit ? bypass_data : mem_read_data;
`else
    assign resp_data = mem_read_data;
`endif

endmodule

// File: doc/dual_port_memory_arbiter.md
# dual_port_memory_arbiter

Shares one `dual_port_memory` instance between `REQUESTERS` clients. Read and write ports are arbitrated independently, each round-robin. Read results return to the winning client one cycle after grant. The block sits between client engines (e.g. DMA, CPU bus bridge) and the memory and drives all memory control pins; all clock enables are tied high.

## Interface
Parameters:
- `WIDTH`, 8: data word width.
- `DEPTH`, 512: memory words; `AW = $clog2(DEPTH)`.
- `REQUESTERS`, 2: client count, 2..8; `IW = $clog2(REQUESTERS)`.

Ports:
- `clock`  in  1  sole clock; memory read and write clocks are driven from it.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  REQUESTERS  client i has a request pending.
- `req_write`  in  REQUESTERS  1 = write, 0 = read; held stable while valid.
- `req_addr`  in  REQUESTERS*AW  packed addresses; client i at [i*AW +: AW].
- `req_data`  in  REQUESTERS*WIDTH  packed write data.
- `req_ready`  out  REQUESTERS  one-hot-or-zero per port type; transfer when valid & ready.
- `resp_valid`  out  REQUESTERS  one-hot; read data for client i valid this cycle.
- `resp_data`  out  WIDTH  shared read data bus.
- `mem_read_enable`  out  1  memory read strobe.
- `mem_read_addr`  out  AW  memory read address.
- `mem_read_data`  in  WIDTH  memory registered read data.
- `mem_write_enable`  out  1  memory write strobe.
- `mem_write_addr`  out  AW  memory write address.
- `mem_write_data`  out  WIDTH  memory write data.

## Operation
- Two arbiters run every cycle.
  - Read arbiter: candidates are clients with `req_valid & ~req_write`.
  - Write arbiter: candidates are clients with `req_valid & req_write`.
- Round-robin pointer `last_read` / `last_write` (IW bits).
  - The winner is the first candidate at index last+1, last+2, … with wrap modulo REQUESTERS.
  - The pointer loads the winner index on any grant and holds when there is no grant.
  - A client requesting continuously is granted at least once every REQUESTERS cycles.
- `req_ready[i]` is combinational from the grant: asserted only for the winner. Grant never depends on ready.
- Memory control is combinational from the grant.
  - `mem_*_enable` = grant exists.
  - Address and data are muxed from the winner. With no grant, address and data = 0.
- Read response:
  - `resp_owner` and `resp_pending` are registered at the grant edge.
  - `resp_valid` = onehot(resp_owner) & resp_pending, asserted the cycle after grant.
  - `resp_data` = `mem_read_data`, or the bypass register (see Configuration).
- One client may hold a read grant and a write grant in the same cycle only if it asserts both. It cannot, since `req_write` is a single bit per client, so the two grants always go to different clients.
- Reset values:
  - `resp_valid` = 0, `resp_pending` = 0.
  - `last_read` = `last_write` = REQUESTERS-1, so client 0 has first priority.
  - Combinational outputs are 0 while no requests are pending.
- Reset asserted mid-read: the pending response is dropped and no `resp_valid` follows.

## Timing
- Grant is zero-latency: ready is asserted in the same cycle as valid when the client wins.
- Write latency: memory is updated at the grant edge.
- Read latency: exactly 1 cycle from accept edge to `resp_valid`.
- Back-to-back reads are supported every cycle; throughput is 1 read plus 1 write per cycle.
- Same-address read and write in the same cycle: the result depends on `DUAL_PORT_ARBITER_BYPASS_EN`.

## Configuration
- Macro: `DUAL_PORT_ARBITER_BYPASS_EN`.
- Defined:
  - On a same-cycle read grant and write grant with equal addresses, the write data is registered.
  - `resp_data` in the response cycle returns the new write data.
- Undefined:
  - `resp_data` = `mem_read_data` always.
  - Collision result is undefined, matching the memory primitive.
  - Clients must avoid collisions.

## Structure
- Package `dual_port_memory_arbiter_pkg`: helper function returning the round-robin winner index and a valid flag from a request mask and a pointer, plus the `IW` width helper.
- Sub-module `round_robin_arbiter` (params `REQUESTERS`; inputs `clock`, `reset_n`, `request` mask; outputs `grant` one-hot and `grant_index`). It owns its pointer and is instantiated twice, once for read and once for write.

## Test plan
- Reset, then client 0 writes 0xA5 to addr 3 while client 1 reads addr 3 one cycle later -> `resp_valid` = 0b10 the next cycle with `resp_data` = 0xA5.
- Clients 0 and 1 both issue continuous reads -> grants alternate 0,1,0,1; client 0 is granted first after reset; each response arrives 1 cycle after its grant.
- Client 0 reads addr 5 while client 1 writes 0x3C to addr 7 in the same cycle -> both ready in the same cycle; the write lands at addr 7; the read returns the prior contents of addr 5.
- Same-cycle read and write of addr 9 (old 0x11, new 0x22) -> with macro, `resp_data` = 0x22; without macro, the check is skipped.
- REQUESTERS=4 with clients 1 and 3 requesting continuously -> grants 1,3,1,3; idle clients are never granted.
- Read accepted, then `reset_n` pulsed low before the response edge -> no `resp_valid`; pointers return to REQUESTERS-1.
